// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: reads the word at pc over a ready-handshake port,
// loads the instruction register, then pulses pc_inc so the PC advances by 4.
module ifetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        pc_inc,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last counter value still allowed to wait; reaching it without mem_rdy aborts.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        mem_rd_q, mem_rd_d;
    logic        busy_q, busy_d;
    logic        ir_valid_q, ir_valid_d;
    logic        pc_inc_q, pc_inc_d;
    logic        fetch_err_q, fetch_err_d;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        mem_rd_d    = 1'b0;
        busy_d      = 1'b0;
        ir_valid_d  = 1'b0;
        pc_inc_d    = 1'b0;
        fetch_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    if (pc[1:0] == 2'b00) begin
                        state_d  = S_RD;
                        addr_d   = pc;
                        cnt_d    = 8'd0;
                        mem_rd_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        fetch_err_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                // Flush beats a same-cycle mem_rdy, which beats the timeout.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_rdy) begin
                    state_d    = S_DONE;
                    ir_d       = mem_rdata;
                    ir_pc_d    = addr_q;
                    busy_d     = 1'b1;
                    ir_valid_d = 1'b1;
                    pc_inc_d   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    mem_rd_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            ir_q        <= 32'd0;
            ir_pc_q     <= 32'd0;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            ir_valid_q  <= 1'b0;
            pc_inc_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            mem_rd_q    <= mem_rd_d;
            busy_q      <= busy_d;
            ir_valid_q  <= ir_valid_d;
            pc_inc_q    <= pc_inc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = mem_rd_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign pc_inc    = pc_inc_q;
    assign busy      = busy_q;
    assign fetch_err = fetch_err_q;

endmodule
